// File: rtl/spi_bus_arbiter_if.sv
// Bundle of the per-handler SPI request lines and the shared SPI pins seen by the arbiter.
// The arbiter connects through the slave modport; the handlers (or a bench) use master.
interface spi_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] o_grant;
  logic [NUM_REQ-1:0] i_req_cs_n;
  logic [NUM_REQ-1:0] i_req_si;
  logic               o_spi_cs_n;
  logic               o_spi_si;
  logic               o_busy;
  logic               o_timeout;

  modport slave (
    input  i_req, i_req_cs_n, i_req_si,
    output o_grant, o_spi_cs_n, o_spi_si, o_busy, o_timeout
  );

  modport master (
    output i_req, i_req_cs_n, i_req_si,
    input  o_grant, o_spi_cs_n, o_spi_si, o_busy, o_timeout
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner arbitration and CS_n/SI muxing for a shared SPI bus, with an idle gap.
// Optional forced release after TIMEOUT_CYCLES of ownership when SPI_ARB_TIMEOUT_EN is defined.
module spi_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               i_sys_clk,
  input  logic               i_reset_n,
  spi_bus_arbiter_if.slave   bus
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               owner_done;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic               timeout_q, timeout_d;

  // A timed-out handler stays out of arbitration until it lets go of its request.
  assign eligible = bus.i_req & ~mask_q;
`else
  assign eligible = bus.i_req;
`endif

  assign owner_done = !bus.i_req[idx_q] && bus.i_req_cs_n[idx_q];

  // Search starts just after the last owner, so a lone requester wraps back to itself.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!pick_found && eligible[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      mask_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
`ifdef SPI_ARB_TIMEOUT_EN
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
    mask_d    = mask_q & bus.i_req;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idx_d             = pick_idx;
          last_d            = pick_idx;
          cnt_d             = '0;
        end
      end
      ST_GRANT: begin
        if (owner_done) begin
          state_d = ST_RELEASE;
          grant_d = '0;
          cnt_d   = '0;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_RELEASE;
          grant_d       = '0;
          cnt_d         = '0;
          timeout_d     = 1'b1;
          mask_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        if (cnt_q >= CNT_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Pins follow the registered owner only; an async reset drops GRANT and frees the bus at once.
  always_comb begin
    bus.o_grant    = grant_q;
    bus.o_busy     = (state_q != ST_IDLE);
    bus.o_spi_cs_n = 1'b1;
    bus.o_spi_si   = 1'b0;
    if (state_q == ST_GRANT) begin
      bus.o_spi_cs_n = bus.i_req_cs_n[idx_q];
      bus.o_spi_si   = bus.i_req_si[idx_q];
    end
`ifdef SPI_ARB_TIMEOUT_EN
    bus.o_timeout = timeout_q;
`else
    bus.o_timeout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: a vector table for basic muxing and release,
// then hand-written sequences for round-robin, torn-transaction hold, async reset and timeout.
module tb_spi_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int GAP     = 2;
  localparam int TMO     = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  spi_bus_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_sys_clk(clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] cs_n;
    logic [1:0] si;
    logic [1:0] grant;
    logic       cs_out;
    logic       si_out;
    logic       busy;
  } vec_t;

  vec_t vecs [13];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] cs_n, input logic [1:0] si);
    bus.i_req      = req;
    bus.i_req_cs_n = cs_n;
    bus.i_req_si   = si;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b11, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit saw_tmo;
    int tmo_at;

    //           req    cs_n   si     grant  cs si busy
    vecs[0]  = '{2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0};
    vecs[1]  = '{2'b01, 2'b11, 2'b00, 2'b01, 1, 0, 1};
    vecs[2]  = '{2'b01, 2'b10, 2'b01, 2'b01, 0, 1, 1};
    vecs[3]  = '{2'b01, 2'b00, 2'b10, 2'b01, 0, 0, 1};
    vecs[4]  = '{2'b01, 2'b11, 2'b01, 2'b01, 1, 1, 1};
    vecs[5]  = '{2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 1};
    vecs[6]  = '{2'b00, 2'b00, 2'b11, 2'b00, 1, 0, 1};
    vecs[7]  = '{2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0};
    vecs[8]  = '{2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0};
    vecs[9]  = '{2'b10, 2'b01, 2'b10, 2'b10, 0, 1, 1};
    vecs[10] = '{2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 1};
    vecs[11] = '{2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 1};
    vecs[12] = '{2'b00, 2'b11, 2'b00, 2'b00, 1, 0, 0};

    rst_n = 1'b1;
    do_reset();
    #1;
    check("reset_grant", 32'(bus.o_grant), 32'h0);
    check("reset_cs_n", 32'(bus.o_spi_cs_n), 32'h1);
    check("reset_si", 32'(bus.o_spi_si), 32'h0);
    check("reset_busy", 32'(bus.o_busy), 32'h0);
    check("reset_timeout", 32'(bus.o_timeout), 32'h0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].req, vecs[i].cs_n, vecs[i].si);
      step();
      check($sformatf("v%0d_grant", i), 32'(bus.o_grant), 32'(vecs[i].grant));
      check($sformatf("v%0d_cs_n", i), 32'(bus.o_spi_cs_n), 32'(vecs[i].cs_out));
      check($sformatf("v%0d_si", i), 32'(bus.o_spi_si), 32'(vecs[i].si_out));
      check($sformatf("v%0d_busy", i), 32'(bus.o_busy), 32'(vecs[i].busy));
    end

    // Simultaneous requests after reset, then round-robin hand-over through the gap.
    do_reset();
    drive(2'b11, 2'b11, 2'b00);
    step();
    check("rr_first_grant", 32'(bus.o_grant), 32'h1);
    drive(2'b10, 2'b11, 2'b00);
    for (int i = 0; i < GAP + 1; i++) begin
      step();
      check($sformatf("rr_gap%0d_grant", i), 32'(bus.o_grant), 32'h0);
      check($sformatf("rr_gap%0d_cs_n", i), 32'(bus.o_spi_cs_n), 32'h1);
    end
    drive(2'b11, 2'b11, 2'b00);
    step();
    check("rr_second_grant", 32'(bus.o_grant), 32'h2);
    drive(2'b01, 2'b11, 2'b00);
    for (int i = 0; i < GAP + 1; i++) begin
      step();
      check($sformatf("rr_back_gap%0d", i), 32'(bus.o_grant), 32'h0);
    end
    step();
    check("rr_back_grant", 32'(bus.o_grant), 32'h1);

    // Lone requester drops briefly and is re-granted after the gap.
    drive(2'b00, 2'b11, 2'b00);
    step();
    check("single_release", 32'(bus.o_grant), 32'h0);
    drive(2'b01, 2'b11, 2'b00);
    step();
    step();
    check("single_idle_busy", 32'(bus.o_busy), 32'h0);
    step();
    check("single_regrant", 32'(bus.o_grant), 32'h1);

    // Request dropped mid-transaction: ownership held until CS_n rises.
    drive(2'b01, 2'b10, 2'b00);
    step();
    drive(2'b00, 2'b10, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("torn_hold%0d", i), 32'(bus.o_grant), 32'h1);
    end
    check("torn_cs_low", 32'(bus.o_spi_cs_n), 32'h0);
    drive(2'b00, 2'b11, 2'b00);
    step();
    check("torn_release", 32'(bus.o_grant), 32'h0);

    // Async reset while the owner holds CS_n low.
    do_reset();
    drive(2'b01, 2'b10, 2'b00);
    step();
    step();
    check("mid_grant_cs_low", 32'(bus.o_spi_cs_n), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(bus.o_grant), 32'h0);
    check("async_rst_cs_n", 32'(bus.o_spi_cs_n), 32'h1);
    check("async_rst_busy", 32'(bus.o_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
    do_reset();
    drive(2'b11, 2'b10, 2'b00);
    saw_tmo = 1'b0;
    tmo_at  = 0;
    for (int i = 1; i <= 40 && !saw_tmo; i++) begin
      step();
      if (bus.o_timeout) begin
        saw_tmo = 1'b1;
        tmo_at  = i;
      end
    end
    check("tmo_seen", 32'(saw_tmo), 32'h1);
    check("tmo_cycle", 32'(tmo_at), 32'(TMO + 1));
    check("tmo_grant", 32'(bus.o_grant), 32'h0);
    check("tmo_cs_n", 32'(bus.o_spi_cs_n), 32'h1);
    step();
    check("tmo_pulse_end", 32'(bus.o_timeout), 32'h0);
    step();
    step();
    check("tmo_other_grant", 32'(bus.o_grant), 32'h2);
    drive(2'b01, 2'b10, 2'b00);
    repeat (8) step();
    check("tmo_masked_grant", 32'(bus.o_grant), 32'h0);
    check("tmo_masked_busy", 32'(bus.o_busy), 32'h0);
    drive(2'b00, 2'b11, 2'b00);
    step();
    drive(2'b01, 2'b11, 2'b00);
    step();
    check("tmo_unmasked_grant", 32'(bus.o_grant), 32'h1);
`else
    do_reset();
    drive(2'b01, 2'b10, 2'b00);
    saw_tmo = 1'b0;
    tmo_at  = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (bus.o_timeout) saw_tmo = 1'b1;
      if (bus.o_grant != 2'b01) tmo_at++;
    end
    check("hold_no_timeout", 32'(saw_tmo), 32'h0);
    check("hold_grant_lost_cycles", 32'(tmo_at), 32'h0);
    check("hold_grant_final", 32'(bus.o_grant), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
